// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the PC sequencer.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } pc_seq_state_t;

  localparam int PC_STEP = 4;
  localparam int INSN_W  = 32;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch bus: imem request/response, decode handoff, redirect and halt control.
interface pc_sequencer_if #(parameter int WIDTH = 32);
  import riscv_pkg::*;

  logic              imem_req;
  logic [WIDTH-1:0]  imem_addr;
  logic              imem_ready;
  logic [INSN_W-1:0] imem_rdata;
  logic              insn_valid;
  logic [INSN_W-1:0] insn;
  logic [WIDTH-1:0]  insn_pc;
  logic              insn_accept;
  logic              redirect_valid;
  logic [WIDTH-1:0]  redirect_addr;
  logic              halt_req;
  logic              halted;
  logic              misalign_err;

  // master is the sequencer, slave is the imem/decode/execute side
  modport master (
    output imem_req, imem_addr, insn_valid, insn, insn_pc, halted, misalign_err,
    input  imem_ready, imem_rdata, insn_accept, redirect_valid, redirect_addr, halt_req
  );

  modport slave (
    input  imem_req, imem_addr, insn_valid, insn, insn_pc, halted, misalign_err,
    output imem_ready, imem_rdata, insn_accept, redirect_valid, redirect_addr, halt_req
  );

endinterface

// File: rtl/pc_sequencer_pc.sv
// Program counter register; loads addressin every cycle, resets to RESET_VAL.
module pc #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] addressin,
  output logic [WIDTH-1:0] addressout
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) addressout <= RESET_VAL;
    else       addressout <= addressin;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, runs a single-outstanding imem fetch and hands
// instructions to decode. Build option MISALIGN_TRAP_EN traps misaligned redirects.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic           clk,
  input  logic           nrst,
  pc_sequencer_if.master bus
);

  pc_seq_state_t     state;
  logic [WIDTH-1:0]  pc_q;
  logic [WIDTH-1:0]  pc_d;
  logic [WIDTH-1:0]  redir_tgt;
  logic [INSN_W-1:0] insn_q;
  logic [WIDTH-1:0]  insn_pc_q;
  logic              redir;
  logic              trap;

  // Redirects are ignored in IDLE so the reset address always reaches the PC.
  assign redir     = bus.redirect_valid && (state != IDLE);
  assign redir_tgt = bus.redirect_addr & ~WIDTH'(3);

  always_comb begin
    pc_d = pc_q;
    if (state == IDLE)                           pc_d = RESET_ADDR;
    else if (redir)                              pc_d = redir_tgt;
    else if (state == HOLD && bus.insn_accept)   pc_d = pc_q + WIDTH'(PC_STEP);
  end

  pc #(.WIDTH(WIDTH), .RESET_VAL(RESET_ADDR)) u_pc (
    .clk       (clk),
    .nrst      (nrst),
    .addressin (pc_d),
    .addressout(pc_q)
  );

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  assign trap = redir && (bus.redirect_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)     misalign_q <= 1'b0;
    else if (trap) misalign_q <= 1'b1;
  end

  assign bus.misalign_err = misalign_q;
`else
  assign trap             = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      insn_q    <= '0;
      insn_pc_q <= '0;
    end else if (redir) begin
      // Redirect wins over any rdata arriving this cycle; a trap overrides halt_req.
      if (trap)              state <= HALTED;
      else if (bus.halt_req) state <= HALTED;
      else                   state <= FETCH;
    end else begin
      case (state)
        IDLE:   state <= bus.halt_req ? HALTED : FETCH;
        FETCH: begin
          if (bus.imem_ready) begin
            insn_q    <= bus.imem_rdata;
            insn_pc_q <= pc_q;
            state     <= HOLD;
          end else if (bus.halt_req) begin
            state <= HALTED;
          end
        end
        HOLD:   if (bus.insn_accept) state <= bus.halt_req ? HALTED : FETCH;
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req   = (state == FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.insn_valid = (state == HOLD);
  assign bus.insn       = insn_q;
  assign bus.insn_pc    = insn_pc_q;
  assign bus.halted     = (state == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: scoreboard queues for fetches and decode handoffs.
module tb_pc_sequencer;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(.WIDTH(32), .RESET_ADDR(32'h0)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == 32'h10) return 32'h00A00093;
    return a ^ 32'hC0DE0000;
  endfunction

  assign bus.imem_rdata = rd_of(bus.imem_addr);

  logic [31:0] exp_fetch[$];
  logic [63:0] exp_insn[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_fetch.push_back(a);
    exp_insn.push_back({a, rd_of(a)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an accepted fetch or a consumed instruction pops the scoreboard.
  always @(negedge clk) begin
    if (nrst) begin
      if (bus.imem_req && bus.imem_ready && !bus.redirect_valid) begin
        if (exp_fetch.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_unexpected: got %h expected none", bus.imem_addr);
        end else begin
          chk("fetch_addr", bus.imem_addr, exp_fetch.pop_front());
        end
      end
      if (bus.insn_valid && bus.insn_accept) begin
        if (exp_insn.size() == 0) begin
          checks++; errors++;
          $display("FAIL insn_unexpected: got %h/%h expected none", bus.insn_pc, bus.insn);
        end else begin
          logic [63:0] e;
          e = exp_insn.pop_front();
          chk("insn_pc", bus.insn_pc, e[63:32]);
          chk("insn",    bus.insn,    e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    nrst = 1'b0;
    bus.imem_ready = 1'b0;
    bus.insn_accept = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    bus.halt_req = 1'b0;
    repeat (3) tick();

    chk("rst_req",      32'(bus.imem_req), 0);
    chk("rst_valid",    32'(bus.insn_valid), 0);
    chk("rst_insn",     bus.insn, 0);
    chk("rst_insn_pc",  bus.insn_pc, 0);
    chk("rst_halted",   32'(bus.halted), 0);
    chk("rst_misalign", 32'(bus.misalign_err), 0);
    chk("rst_addr",     bus.imem_addr, 0);

    // Streaming: ready and accept held high
    bus.imem_ready = 1'b1;
    bus.insn_accept = 1'b1;
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    @(posedge clk); #1; nrst = 1'b1;          // IDLE cycle
    chk("idle_req", 32'(bus.imem_req), 0);
    tick();                                   // FETCH @0
    chk("c1_req",   32'(bus.imem_req), 1);
    chk("c1_valid", 32'(bus.insn_valid), 0);
    tick();                                   // HOLD, first valid
    chk("c2_valid", 32'(bus.insn_valid), 1);
    chk("c2_pc",    bus.insn_pc, 32'h0);
    repeat (6) tick();                        // through HOLD of 0xC
    bus.imem_ready = 1'b0;
    tick();                                   // FETCH @0x10

    // Wait states at 0x10, then decode stall
    push(32'h10);
    bus.insn_accept = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req",  32'(bus.imem_req), 1);
      chk("wait_addr", bus.imem_addr, 32'h10);
      tick();
    end
    bus.imem_ready = 1'b1;
    tick();                                   // HOLD 0x10
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 32'(bus.insn_valid), 1);
      chk("stall_insn",  bus.insn, 32'h00A00093);
      chk("stall_pc",    bus.insn_pc, 32'h10);
      chk("stall_req",   32'(bus.imem_req), 0);
      tick();
    end
    bus.insn_accept = 1'b1;
    tick();                                   // FETCH @0x14
    chk("next_addr", bus.imem_addr, 32'h14);

    // Redirect colliding with imem_ready
    bus.insn_accept = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 32'h40;
    tick();                                   // FETCH @0x40
    chk("redir_addr40", bus.imem_addr, 32'h40);
    bus.imem_ready = 1'b1;
    bus.redirect_addr = 32'h200;
    tick();
    chk("drop_valid", 32'(bus.insn_valid), 0);
    chk("drop_addr",  bus.imem_addr, 32'h200);
    chk("drop_req",   32'(bus.imem_req), 1);
    bus.redirect_valid = 1'b0;
    push(32'h200);
    tick();                                   // HOLD 0x200
    chk("h200_pc", bus.insn_pc, 32'h200);
    bus.imem_ready = 1'b0;
    bus.insn_accept = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 32'h300;
    tick();                                   // redirect beats PC+4
    chk("racc_addr",  bus.imem_addr, 32'h300);
    chk("racc_valid", 32'(bus.insn_valid), 0);

    // Halt and resume
    bus.insn_accept = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.halt_req = 1'b1;
    tick();
    chk("halt_halted", 32'(bus.halted), 1);
    chk("halt_req",    32'(bus.imem_req), 0);
    chk("halt_valid",  32'(bus.insn_valid), 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 32'h90;
    tick();
    chk("hredir_halted", 32'(bus.halted), 1);
    chk("hredir_addr",   bus.imem_addr, 32'h90);
    bus.halt_req = 1'b0;
    bus.redirect_addr = 32'h80;
    tick();
    chk("resume_halted", 32'(bus.halted), 0);
    chk("resume_req",    32'(bus.imem_req), 1);
    chk("resume_addr",   bus.imem_addr, 32'h80);

    // Wrap at the top of the address space; halt waits for accept
    bus.redirect_addr = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_ready = 1'b1;
    push(32'hFFFF_FFFC);
    tick();                                   // HOLD 0xFFFFFFFC
    bus.imem_ready = 1'b0;
    bus.halt_req = 1'b1;
    tick();
    chk("hold_halt_valid", 32'(bus.insn_valid), 1);
    chk("hold_halt_pc",    bus.insn_pc, 32'hFFFF_FFFC);
    chk("hold_halt_state", 32'(bus.halted), 0);
    bus.insn_accept = 1'b1;
    tick();
    chk("wrap_halted", 32'(bus.halted), 1);
    chk("wrap_addr",   bus.imem_addr, 32'h0);
    bus.halt_req = 1'b0;
    bus.insn_accept = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 32'h0;
    tick();
    chk("wrap_fetch", bus.imem_addr, 32'h0);
    bus.redirect_valid = 1'b0;
    bus.imem_ready = 1'b1;
    push(32'h0);
    tick();                                   // HOLD 0x0
    bus.imem_ready = 1'b0;
    bus.insn_accept = 1'b1;
    tick();                                   // FETCH @4
    chk("post_wrap_addr", bus.imem_addr, 32'h4);

    // Misaligned redirect
    bus.insn_accept = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 32'h102;
    tick();
    chk("mis_addr", bus.imem_addr, 32'h100);
`ifdef MISALIGN_TRAP_EN
    chk("mis_halted", 32'(bus.halted), 1);
    chk("mis_err",    32'(bus.misalign_err), 1);
`else
    chk("mis_halted", 32'(bus.halted), 0);
    chk("mis_req",    32'(bus.imem_req), 1);
    chk("mis_err",    32'(bus.misalign_err), 0);
`endif
    bus.redirect_addr = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    chk("mis_resume_req", 32'(bus.imem_req), 1);
`ifdef MISALIGN_TRAP_EN
    chk("mis_sticky", 32'(bus.misalign_err), 1);
`else
    chk("mis_sticky", 32'(bus.misalign_err), 0);
`endif

    chk("fetch_q_empty", 32'(exp_fetch.size()), 0);
    chk("insn_q_empty",  32'(exp_insn.size()), 0);

    // Asynchronous reset in the middle of a fetch
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_req",      32'(bus.imem_req), 0);
    chk("arst_addr",     bus.imem_addr, 32'h0);
    chk("arst_halted",   32'(bus.halted), 0);
    chk("arst_misalign", 32'(bus.misalign_err), 0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
